// File: rtl/nor_bridge_pkg.sv
// rtl/nor_bridge_pkg.sv - shared types and constants for the NOR bus arbiter
package nor_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_ABORT = 2'd2
   } arb_state_t;

   localparam int M_QSPI      = 0;
   localparam int M_AUX       = 1;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_TIMEOUT = 1024;
   localparam int DEF_MAX_OUT = 4;

   function automatic logic [1:0] owner_onehot(input logic owner);
      logic [1:0] oh;
      oh         = 2'b00;
      oh[M_QSPI] = (owner == 1'b0);
      oh[M_AUX]  = (owner == 1'b1);
      return oh;
   endfunction

endpackage

// File: rtl/wb_nor_arbiter_if.sv
// rtl/wb_nor_arbiter_if.sv - two-master Wishbone side plus NOR controller side
interface wb_nor_arbiter_if #(parameter int ADDR_W = 32);

   logic [1:0]          m_cyc_i;
   logic [1:0]          m_stb_i;
   logic [1:0]          m_we_i;
   logic [2*ADDR_W-1:0] m_adr_i;
   logic [31:0]         m_dat_i;
   logic [15:0]         m_dat_o;
   logic [1:0]          m_ack_o;
   logic [1:0]          m_err_o;
   logic [1:0]          m_stall_o;
   logic                s_cyc_o;
   logic                s_stb_o;
   logic                s_we_o;
   logic [ADDR_W-1:0]   s_adr_o;
   logic [15:0]         s_dat_o;
   logic [15:0]         s_dat_i;
   logic                s_ack_i;
   logic                s_err_i;
   logic                s_stall_i;
   logic [1:0]          gnt_o;
   logic                timeout_o;

   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i,
      input  s_dat_i, s_ack_i, s_err_i, s_stall_i,
      output m_dat_o, m_ack_o, m_err_o, m_stall_o,
      output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
      output gnt_o, timeout_o
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i,
      output s_dat_i, s_ack_i, s_err_i, s_stall_i,
      input  m_dat_o, m_ack_o, m_err_o, m_stall_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
      input  gnt_o, timeout_o
   );

endinterface

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - response watchdog; expires after TIMEOUT enabled cycles
module wb_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_at_limit;

   assign w_at_limit = (r_cnt == CW'(TIMEOUT - 1));
   assign expire_o   = enable_i & ~clear_i & w_at_limit;

   always_ff @(posedge clk_i) begin
      if (reset_i || clear_i) begin
         r_cnt <= '0;
      end else if (enable_i) begin
         r_cnt <= w_at_limit ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/wb_nor_arbiter.sv
// rtl/wb_nor_arbiter.sv - round-robin two-master Wishbone arbiter in front of
// the NOR controller, with outstanding-request limit and response watchdog
module wb_nor_arbiter
   import nor_bridge_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int MAX_OUT = DEF_MAX_OUT
) (
   input  logic              clk_i,
   input  logic              reset_i,
   wb_nor_arbiter_if.slave   bus
);

   localparam int OW = $clog2(MAX_OUT + 1);

   arb_state_t    r_state, w_state_nxt;
   logic          r_owner, w_owner_nxt;
   logic          r_last;
   logic [OW-1:0] r_out, w_out_nxt;
   logic          w_own_cyc, w_full, w_pend, w_resp, w_stb, w_accept;
   logic          w_expire, w_abort;

   assign w_own_cyc = bus.m_cyc_i[r_owner];
   assign w_full    = (r_out == OW'(MAX_OUT));
   assign w_pend    = (r_out != '0);
   // responses with nothing outstanding are strays and never reach a master
   assign w_resp    = (bus.s_ack_i | bus.s_err_i) & w_pend;
   assign w_stb     = (r_state == ST_OWN) & w_own_cyc & bus.m_stb_i[r_owner] & ~w_full;
   assign w_accept  = w_stb & ~bus.s_stall_i;

   assign bus.s_stb_o   = w_stb;
   assign bus.m_dat_o   = bus.s_dat_i;
   assign bus.timeout_o = w_abort;

   wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .clear_i  ((r_state != ST_OWN) | ~w_pend | bus.s_ack_i | bus.s_err_i),
      .enable_i (w_pend),
      .expire_o (w_expire)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_owner_nxt   = r_owner;
      w_abort       = 1'b0;
      bus.s_cyc_o   = 1'b0;
      bus.s_we_o    = 1'b0;
      bus.s_adr_o   = '0;
      bus.s_dat_o   = '0;
      bus.m_ack_o   = 2'b00;
      bus.m_err_o   = 2'b00;
      bus.m_stall_o = 2'b11;
      bus.gnt_o     = 2'b00;
      case (r_state)
         ST_IDLE: begin
            if (|bus.m_cyc_i) begin
               w_state_nxt = ST_OWN;
               w_owner_nxt = (&bus.m_cyc_i) ? ~r_last : bus.m_cyc_i[1];
            end
         end
         ST_OWN: begin
            bus.gnt_o                = owner_onehot(r_owner);
            bus.s_cyc_o              = w_own_cyc;
            bus.s_we_o               = bus.m_we_i[r_owner];
            bus.s_adr_o              = r_owner ? bus.m_adr_i[2*ADDR_W-1:ADDR_W]
                                               : bus.m_adr_i[ADDR_W-1:0];
            bus.s_dat_o              = r_owner ? bus.m_dat_i[31:16] : bus.m_dat_i[15:0];
            bus.m_stall_o[r_owner]   = bus.s_stall_i | w_full;
            bus.m_ack_o[r_owner]     = bus.s_ack_i & w_pend;
            bus.m_err_o[r_owner]     = bus.s_err_i & w_pend;
            if (!w_own_cyc) begin
               w_state_nxt = ST_IDLE;
            end else if (w_expire) begin
               w_abort              = 1'b1;
               bus.m_err_o[r_owner] = 1'b1;
               w_state_nxt          = ST_ABORT;
            end
         end
         ST_ABORT: begin
            bus.gnt_o = owner_onehot(r_owner);
            if (!w_own_cyc) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_out_nxt = '0;
      if (r_state == ST_OWN && w_state_nxt == ST_OWN) begin
         w_out_nxt = r_out;
         if (w_accept && !w_resp) begin
            w_out_nxt = r_out + 1'b1;
         end else if (!w_accept && w_resp) begin
            w_out_nxt = r_out - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= ST_IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
         r_out   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_out   <= w_out_nxt;
         if (r_state != ST_IDLE && w_state_nxt == ST_IDLE) begin
            r_last <= r_owner;
         end
      end
   end

endmodule

// File: doc/wb_nor_arbiter.md
WB_NOR_ARBITER -- requirements
Module: wb_nor_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, Wishbone address width.
REQ-002 SHALL have parameter TIMEOUT, default 1024, cycles without slave response before abort.
REQ-003 SHALL have parameter MAX_OUT, default 4, maximum outstanding pipelined requests.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 m_cyc_i  input  2  per-master cycle (bit 0 = QSPI bridge, bit 1 = second master).
REQ-007 m_stb_i  input  2  per-master strobe.
REQ-008 m_we_i  input  2  per-master write enable.
REQ-009 m_adr_i  input  2*ADDR_W  packed addresses, master 0 in low half.
REQ-010 m_dat_i  input  32  packed 16-bit write data, master 0 in low half.
REQ-011 m_dat_o  output  16  read data to both masters, equals s_dat_i.
REQ-012 m_ack_o / m_err_o / m_stall_o  output  2 each  per-master ack, error, stall.
REQ-013 s_cyc_o, s_stb_o, s_we_o  output  1 each  to NOR controller.
REQ-014 s_adr_o  output  ADDR_W; s_dat_o  output  16  muxed from owner.
REQ-015 s_dat_i  input  16; s_ack_i, s_err_i, s_stall_i  input  1 each  from NOR controller.
REQ-016 gnt_o  output  2  one-hot current owner (debug); timeout_o  output  1  one-cycle abort pulse.

Function
REQ-017 States SHALL be IDLE, OWN, ABORT; registered owner bit, last-owner bit, outstanding counter (0..MAX_OUT), watchdog counter.
REQ-018 IDLE: any m_cyc_i set -> OWN next cycle; owner = sole requester, or on tie the master != last-owner (round robin).
REQ-019 During IDLE all m_stall_o SHALL be 1 and s_cyc_o 0; first owner stb reaches slave no earlier than one cycle after request.
REQ-020 OWN: s_cyc_o = m_cyc_i[owner]; s_stb_o/we/adr/dat passthrough from owner, combinational.
REQ-021 Owner m_stall_o = s_stall_i OR outstanding==MAX_OUT; when outstanding==MAX_OUT s_stb_o SHALL be 0; non-owner m_stall_o = 1, ack/err = 0.
REQ-022 Outstanding SHALL +1 on s_stb_o&~stall, -1 on s_ack_i|s_err_i, unchanged when both same cycle.
REQ-023 s_ack_i/s_err_i SHALL route only to owner, same cycle.
REQ-024 OWN with owner m_cyc_i=0 -> IDLE next cycle, outstanding cleared, last-owner = owner; minimum one dead IDLE cycle between grants.
REQ-025 Watchdog SHALL count while outstanding>0 and no ack/err; reset on ack/err or outstanding==0.
REQ-026 Watchdog reaching TIMEOUT-1: pulse m_err_o[owner] and timeout_o one cycle, enter ABORT.
REQ-027 ABORT: s_cyc_o=0, owner m_stall_o=1, slave ack/err discarded; owner m_cyc_i=0 -> IDLE.
REQ-028 Stray s_ack_i/s_err_i with outstanding==0 SHALL be discarded, counter not decremented below 0.

Reset
REQ-029 reset_i SHALL force IDLE, outstanding=0, watchdog=0, last-owner=1 (master 0 wins first tie), gnt_o=0, timeout_o=0, all m_ack_o/m_err_o=0, m_stall_o=2'b11, s_cyc_o=s_stb_o=0; reset mid-transaction drops s_cyc_o next edge.

Structure
REQ-030 State encoding, master index constants and default TIMEOUT/MAX_OUT SHALL live in shared package nor_bridge_pkg.
REQ-031 Watchdog SHALL be sub-module wb_watchdog (clear, enable, expire pulse); rest flat.

Verification
REQ-032 Only m0 reads 0x0000_1000, slave acks after 3 cycles -> gnt_o=01, m_ack_o[0] pulse, m_dat_o=slave data.
REQ-033 Both cyc same cycle after reset -> m0 granted; m0 releases, both still request -> m1 granted after one IDLE cycle.
REQ-034 m0 issues 6 back-to-back stb, slave never stalls, ack delayed -> exactly 4 accepted, then m_stall_o[0]=1 until first ack.
REQ-035 Slave never acks, TIMEOUT=16 -> m_err_o[0] and timeout_o pulse 16 cycles after stb, s_cyc_o=0; late s_ack_i ignored.
REQ-036 reset_i asserted with 2 outstanding -> next cycle s_cyc_o=0, gnt_o=0, m_stall_o=11; next grant ties to m0.
